// File: rtl/leitor7seg_pkg.sv
// Shared constants for the 7-segment display bus reader: segment patterns,
// digit-enable codes, FSM encoding and the BCD-to-binary helper.
package leitor7seg_pkg;

  localparam logic [6:0] SEG_0      = 7'h40;
  localparam logic [6:0] SEG_1      = 7'h79;
  localparam logic [6:0] SEG_2      = 7'h24;
  localparam logic [6:0] SEG_3      = 7'h30;
  localparam logic [6:0] SEG_4      = 7'h19;
  localparam logic [6:0] SEG_5      = 7'h12;
  localparam logic [6:0] SEG_6      = 7'h02;
  localparam logic [6:0] SEG_7      = 7'h78;
  localparam logic [6:0] SEG_8      = 7'h00;
  localparam logic [6:0] SEG_9      = 7'h10;
  localparam logic [6:0] SEG_BRANCO = 7'h7F;

  localparam logic [3:0] EN_POS0 = 4'b1110;
  localparam logic [3:0] EN_POS1 = 4'b1101;
  localparam logic [3:0] EN_POS2 = 4'b1011;
  localparam logic [3:0] EN_POS3 = 4'b0111;

  typedef enum logic [2:0] {
    SINC     = 3'd0,
    C_DEZ    = 3'd1,
    C_CEN    = 3'd2,
    AVALIA   = 3'd3,
    C_BRANCO = 3'd4,
    C_UNI    = 3'd5
  } estado_t;

  // Three BCD digits to binary; 10 bits covers the worst case of 999.
  function automatic logic [9:0] calc_valor(input logic [3:0] cen,
                                            input logic [3:0] dez,
                                            input logic [3:0] uni);
    return ({6'd0, cen} * 10'd100) + ({6'd0, dez} * 10'd10) + {6'd0, uni};
  endfunction

endpackage

// File: rtl/leitor7seg_seg2bcd.sv
// Combinational decode of an active-low {g..a} segment pattern into BCD,
// flagging digits and the blank pattern; anything else is a non-digit.
module leitor7seg_seg2bcd
  import leitor7seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       eh_digito,
  output logic       eh_branco
);

  // Exact pattern match; letters and partial patterns fall to default
  always_comb begin
    bcd       = 4'd0;
    eh_digito = 1'b1;
    eh_branco = 1'b0;
    case (seg)
      SEG_0:      bcd = 4'd0;
      SEG_1:      bcd = 4'd1;
      SEG_2:      bcd = 4'd2;
      SEG_3:      bcd = 4'd3;
      SEG_4:      bcd = 4'd4;
      SEG_5:      bcd = 4'd5;
      SEG_6:      bcd = 4'd6;
      SEG_7:      bcd = 4'd7;
      SEG_8:      bcd = 4'd8;
      SEG_9:      bcd = 4'd9;
      SEG_BRANCO: begin
        eh_digito = 1'b0;
        eh_branco = 1'b1;
      end
      default:    eh_digito = 1'b0;
    endcase
  end

endmodule

// File: rtl/leitor7seg.sv
// Multiplexed 7-segment bus reader: filters and decodes the digit scan,
// reassembles the displayed 0..255 value and strobes each valid frame.
module leitor7seg
  import leitor7seg_pkg::*;
#(
  parameter int ESTAVEL = 1,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        clock,
  input  logic        zera_s_n,
  input  logic [11:0] display,
  output logic [7:0]  numero,
  output logic [11:0] digitos,
  output logic        novo_valor,
  output logic        erro,
  output logic        sincronizado
);

  localparam int EW = $clog2(ESTAVEL + 2);

  logic [11:0]   display_r, anterior_r;
  logic [EW-1:0] est_cnt_r, est_prox_s;
  logic [TW-1:0] tmo_cnt_r;
  logic          en_valido_s, captura_s, falha_s, avanca_s;
  logic [1:0]    pos_s;
  logic [3:0]    bcd_s, uni_r, dez_r, cen_r;
  logic          eh_digito_s, eh_branco_s;
  logic [9:0]    soma_s;
  estado_t       estado_r;
  logic [7:0]    numero_r;
  logic [11:0]   digitos_r;
  logic          novo_valor_r, erro_r, sincronizado_r;

  leitor7seg_seg2bcd u_seg2bcd (
    .seg       (display_r[6:0]),
    .bcd       (bcd_s),
    .eh_digito (eh_digito_s),
    .eh_branco (eh_branco_s)
  );

  // Digit-enable decode; non one-hot codes are invalid
  always_comb begin
    en_valido_s = 1'b1;
    pos_s       = 2'd0;
    case (display_r[11:8])
      EN_POS0: pos_s = 2'd0;
      EN_POS1: pos_s = 2'd1;
      EN_POS2: pos_s = 2'd2;
      EN_POS3: pos_s = 2'd3;
      default: en_valido_s = 1'b0;
    endcase
  end

  // Run length of the current pair, saturating past ESTAVEL so it fires once
  always_comb begin
    if ((display_r == anterior_r) && (est_cnt_r != {EW{1'b0}})) begin
      if (est_cnt_r == EW'(ESTAVEL + 1)) begin
        est_prox_s = est_cnt_r;
      end else begin
        est_prox_s = est_cnt_r + 1'b1;
      end
    end else begin
      est_prox_s = EW'(1);
    end
    captura_s = en_valido_s && (est_prox_s == EW'(ESTAVEL));
    soma_s    = calc_valor(cen_r, dez_r, uni_r);
  end

  // Judge a capture against what the current state expects
  always_comb begin
    falha_s  = 1'b0;
    avanca_s = 1'b0;
    if (captura_s) begin
      case (estado_r)
        C_DEZ:    avanca_s = (pos_s == 2'd1) && eh_digito_s;
        C_CEN:    avanca_s = (pos_s == 2'd2) && eh_digito_s;
        C_UNI:    avanca_s = (pos_s == 2'd0) && eh_digito_s;
        C_BRANCO: avanca_s = ((pos_s == 2'd3) && eh_branco_s) ||
                             ((pos_s == 2'd0) && eh_digito_s);
        default:  avanca_s = 1'b0;
      endcase
      falha_s = !avanca_s && (estado_r != SINC) && (estado_r != AVALIA);
    end else begin
      falha_s  = 1'b0;
      avanca_s = 1'b0;
    end
  end

  // Input register and glitch-filter run counter
  always_ff @(posedge clock) begin
    if (!zera_s_n) begin
      display_r  <= 12'h000;
      anterior_r <= 12'h000;
      est_cnt_r  <= {EW{1'b0}};
    end else begin
      display_r  <= display;
      anterior_r <= display_r;
      est_cnt_r  <= en_valido_s ? est_prox_s : {EW{1'b0}};
    end
  end

  // Frame FSM, timeout counter and registered outputs
  always_ff @(posedge clock) begin
    if (!zera_s_n) begin
      estado_r       <= SINC;
      tmo_cnt_r      <= {TW{1'b0}};
      uni_r          <= 4'd0;
      dez_r          <= 4'd0;
      cen_r          <= 4'd0;
      numero_r       <= 8'd0;
      digitos_r      <= 12'h000;
      novo_valor_r   <= 1'b0;
      erro_r         <= 1'b0;
      sincronizado_r <= 1'b0;
    end else begin
      novo_valor_r <= 1'b0;
      erro_r       <= 1'b0;
      if (captura_s) begin
        tmo_cnt_r <= {TW{1'b0}};
      end else if (tmo_cnt_r != TW'(TIMEOUT)) begin
        tmo_cnt_r <= tmo_cnt_r + 1'b1;
      end
      if (falha_s) begin
        // Drop lock, then give the offending capture a chance to start a frame
        erro_r         <= 1'b1;
        sincronizado_r <= 1'b0;
        if ((pos_s == 2'd0) && eh_digito_s) begin
          uni_r    <= bcd_s;
          estado_r <= C_DEZ;
        end else begin
          estado_r <= SINC;
        end
      end else if (avanca_s) begin
        case (estado_r)
          C_DEZ: begin
            dez_r    <= bcd_s;
            estado_r <= C_CEN;
          end
          C_CEN: begin
            cen_r    <= bcd_s;
            estado_r <= AVALIA;
          end
          C_BRANCO: begin
            if (pos_s == 2'd3) begin
              estado_r <= C_UNI;
            end else begin
              uni_r    <= bcd_s;
              estado_r <= C_DEZ;
            end
          end
          default: begin
            uni_r    <= bcd_s;
            estado_r <= C_DEZ;
          end
        endcase
      end else begin
        case (estado_r)
          SINC: begin
            if (captura_s && (pos_s == 2'd0) && eh_digito_s) begin
              uni_r    <= bcd_s;
              estado_r <= C_DEZ;
            end
          end
          AVALIA: begin
            if (soma_s <= 10'd255) begin
              numero_r       <= soma_s[7:0];
              digitos_r      <= {cen_r, dez_r, uni_r};
              novo_valor_r   <= 1'b1;
              sincronizado_r <= 1'b1;
              estado_r       <= C_BRANCO;
            end else begin
              erro_r         <= 1'b1;
              sincronizado_r <= 1'b0;
              estado_r       <= SINC;
            end
          end
          default: begin
            if (tmo_cnt_r == TW'(TIMEOUT)) begin
              sincronizado_r <= 1'b0;
              estado_r       <= SINC;
            end
          end
        endcase
      end
    end
  end

  assign numero       = numero_r;
  assign digitos      = digitos_r;
  assign novo_valor   = novo_valor_r;
  assign erro         = erro_r;
  assign sincronizado = sincronizado_r;

endmodule

// File: tb/tb_leitor7seg.sv
// Scoreboard bench for leitor7seg: a scan driver pushes expected values,
// a negedge monitor pops them on each novo_valor strobe.
module tb_leitor7seg;

  localparam int H = 4;

  logic        clock = 1'b0;
  logic        zera_s_n;
  logic [11:0] display, display3;
  logic [7:0]  numero, numero3;
  logic [11:0] digitos, digitos3;
  logic        novo_valor, erro, sincronizado;
  logic        novo3, erro3, sinc3;

  int q[$];
  int n_total = 0;
  int n_ok = 0;
  int erro_cnt = 0;
  int erro3_cnt = 0;
  int novo3_cnt = 0;

  logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clock = ~clock;

  leitor7seg u_dut (
    .clock(clock), .zera_s_n(zera_s_n), .display(display),
    .numero(numero), .digitos(digitos), .novo_valor(novo_valor),
    .erro(erro), .sincronizado(sincronizado)
  );

  leitor7seg #(.ESTAVEL(3), .TIMEOUT(64), .TW(7)) u_dut3 (
    .clock(clock), .zera_s_n(zera_s_n), .display(display3),
    .numero(numero3), .digitos(digitos3), .novo_valor(novo3),
    .erro(erro3), .sincronizado(sinc3)
  );

  task automatic verifica(input string tag, input int obs, input int esp);
    n_total++;
    if (obs == esp) n_ok++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, esp);
  endtask

  function automatic int bcd_de(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic slot(input bit alvo3, input logic [3:0] en,
                      input logic [6:0] seg, input int n);
    if (alvo3) display3 = {en, 1'b1, seg};
    else display = {en, 1'b1, seg};
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic quadro(input int v, input bit espera);
    slot(1'b0, 4'b1110, tab[v % 10], H);
    slot(1'b0, 4'b1101, tab[(v / 10) % 10], H);
    if (espera) q.push_back(v);
    slot(1'b0, 4'b1011, tab[(v / 100) % 10], H);
    slot(1'b0, 4'b0111, 7'h7F, H);
  endtask

  always @(negedge clock) begin
    if (novo_valor) begin
      if (q.size() == 0) begin
        verifica("novo_extra", 1, 0);
      end else begin
        int v;
        v = q.pop_front();
        verifica("numero", int'(numero), v);
        verifica("digitos", int'(digitos), bcd_de(v));
      end
    end
    if (erro) erro_cnt++;
    if (erro3) erro3_cnt++;
    if (novo3) novo3_cnt++;
  end

  initial begin
    int espera_ciclos;
    display  = 12'hFFF;
    display3 = 12'hFFF;
    zera_s_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    verifica("rst_numero", int'(numero), 0);
    verifica("rst_digitos", int'(digitos), 0);
    verifica("rst_novo", int'(novo_valor), 0);
    verifica("rst_erro", int'(erro), 0);
    verifica("rst_sinc", int'(sincronizado), 0);
    @(posedge clock);
    #1 zera_s_n = 1'b1;

    // loopback of 173
    repeat (3) quadro(173, 1'b1);
    verifica("sinc_173", int'(sincronizado), 1);
    verifica("erro_173", erro_cnt, 0);

    // 255, 000, then out-of-range 300
    quadro(255, 1'b1);
    quadro(0, 1'b1);
    quadro(300, 1'b0);
    verifica("erro_300", erro_cnt, 1);
    verifica("numero_300", int'(numero), 0);
    verifica("sinc_300", int'(sincronizado), 0);

    // letter at pos1, then a clean 42
    slot(1'b0, 4'b1110, tab[2], H);
    slot(1'b0, 4'b1101, 7'h08, H);
    verifica("erro_letra", erro_cnt, 2);
    quadro(42, 1'b1);
    verifica("sinc_42", int'(sincronizado), 1);

    // out-of-order enables, then an invalid enable inside a frame
    quadro(99, 1'b1);
    slot(1'b0, 4'b1110, tab[9], H);
    slot(1'b0, 4'b1011, tab[9], H);
    verifica("erro_ordem", erro_cnt, 3);
    verifica("sinc_ordem", int'(sincronizado), 0);
    slot(1'b0, 4'b1110, tab[5], H);
    slot(1'b0, 4'b1100, tab[8], 5);
    slot(1'b0, 4'b1101, tab[4], H);
    q.push_back(45);
    slot(1'b0, 4'b1011, tab[0], H);
    slot(1'b0, 4'b0111, 7'h7F, H);
    verifica("erro_invalido", erro_cnt, 3);
    verifica("sinc_45", int'(sincronizado), 1);

    // stalled scan
    slot(1'b0, 4'b0111, 7'h7F, 80);
    verifica("sinc_timeout", int'(sincronizado), 0);
    verifica("erro_timeout", erro_cnt, 3);

    // glitch filter with ESTAVEL=3
    slot(1'b1, 4'b1110, tab[3], 6);
    slot(1'b1, 4'b1101, tab[2], 2);
    slot(1'b1, 4'b1101, tab[8], 1);
    slot(1'b1, 4'b1101, tab[2], 5);
    slot(1'b1, 4'b1011, tab[1], 6);
    slot(1'b1, 4'b0111, 7'h7F, 6);
    verifica("glitch_numero", int'(numero3), 123);
    verifica("glitch_digitos", int'(digitos3), 12'h123);
    verifica("glitch_novo", novo3_cnt, 1);
    verifica("glitch_erro", erro3_cnt, 0);

    // reset while in C_CEN
    slot(1'b0, 4'b1110, tab[5], H);
    slot(1'b0, 4'b1101, tab[6], H);
    zera_s_n = 1'b0;
    @(posedge clock);
    #1 zera_s_n = 1'b1;
    @(negedge clock);
    verifica("rst2_numero", int'(numero), 0);
    verifica("rst2_digitos", int'(digitos), 0);
    verifica("rst2_sinc", int'(sincronizado), 0);
    verifica("rst2_novo", int'(novo_valor), 0);
    verifica("rst2_erro", int'(erro), 0);
    @(posedge clock);
    #1;
    quadro(7, 1'b1);

    espera_ciclos = 0;
    while (q.size() != 0 && espera_ciclos < 50) begin
      @(posedge clock);
      espera_ciclos++;
    end
    verifica("fila_vazia", q.size(), 0);
    verifica("erro_total", erro_cnt, 3);
    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
